// File: rtl/mfb_splitter_n.sv
// Steers MVB headers and their MFB frames to one of OUTPUTS streams; out-of-range indices are
// dropped and counted. Define MFB_SPLITTER_N_STATS_EN to add per-output frame counters.
module mfb_splitter_n #(
    parameter int OUTPUTS        = 4,
    parameter int SW_WIDTH       = (OUTPUTS > 2) ? $clog2(OUTPUTS) : 1,
    parameter int HDR_WIDTH      = 128,
    parameter int MFB_BLOCK_SIZE = 8,
    parameter int MFB_ITEM_WIDTH = 32,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                                                CLK,
    input  logic                                                RESET,
    input  logic [HDR_WIDTH-1:0]                                RX_MVB_HDR,
    input  logic [SW_WIDTH-1:0]                                 RX_MVB_SWITCH,
    input  logic                                                RX_MVB_PAYLOAD,
    input  logic                                                RX_MVB_SRC_RDY,
    output logic                                                RX_MVB_DST_RDY,
    input  logic [MFB_BLOCK_SIZE*MFB_ITEM_WIDTH-1:0]            RX_MFB_DATA,
    input  logic                                                RX_MFB_SOF,
    input  logic                                                RX_MFB_EOF,
    input  logic [$clog2(MFB_BLOCK_SIZE)-1:0]                   RX_MFB_EOF_POS,
    input  logic                                                RX_MFB_SRC_RDY,
    output logic                                                RX_MFB_DST_RDY,
    output logic [OUTPUTS*HDR_WIDTH-1:0]                        TX_MVB_HDR,
    output logic [OUTPUTS-1:0]                                  TX_MVB_PAYLOAD,
    output logic [OUTPUTS-1:0]                                  TX_MVB_SRC_RDY,
    input  logic [OUTPUTS-1:0]                                  TX_MVB_DST_RDY,
    output logic [OUTPUTS*MFB_BLOCK_SIZE*MFB_ITEM_WIDTH-1:0]    TX_MFB_DATA,
    output logic [OUTPUTS-1:0]                                  TX_MFB_SOF,
    output logic [OUTPUTS-1:0]                                  TX_MFB_EOF,
    output logic [OUTPUTS*$clog2(MFB_BLOCK_SIZE)-1:0]           TX_MFB_EOF_POS,
    output logic [OUTPUTS-1:0]                                  TX_MFB_SRC_RDY,
    input  logic [OUTPUTS-1:0]                                  TX_MFB_DST_RDY,
    output logic [CNT_WIDTH-1:0]                                DROP_CNT
`ifdef MFB_SPLITTER_N_STATS_EN
    ,
    output logic [OUTPUTS*CNT_WIDTH-1:0]                        TX_FRAME_CNT
`endif
);

    typedef enum logic [1:0] {StWaitHdr, StSendHdr, StSendFrame} state_t;

    state_t                 r_state;
    logic [HDR_WIDTH-1:0]   r_hdr;
    logic                   r_payload;
    logic                   r_drop;
    logic [OUTPUTS-1:0]     r_sel_oh;
    logic [OUTPUTS-1:0]     r_mvb_vld;
    logic [CNT_WIDTH-1:0]   r_drop_cnt;

    logic [OUTPUTS-1:0]     w_in_oh;
    logic                   w_in_drop;
    logic                   w_hdr_xfer;
    logic                   w_hdr_done;
    logic                   w_in_frame;
    logic                   w_frame_xfer;

    // Index decode; an out-of-range index leaves the one-hot empty.
    always_comb begin
        w_in_oh = '0;
        for (int i = 0; i < OUTPUTS; i++) begin
            w_in_oh[i] = (int'(RX_MVB_SWITCH) == i);
        end
    end

    assign w_in_drop      = (int'(RX_MVB_SWITCH) >= OUTPUTS);
    assign RX_MVB_DST_RDY = !RESET && (r_state == StWaitHdr);
    assign w_hdr_xfer     = RX_MVB_SRC_RDY && RX_MVB_DST_RDY;
    assign w_hdr_done     = r_drop || (|(r_mvb_vld & TX_MVB_DST_RDY));

    // Frame phase: dropped frames are sunk, others follow the selected output's ready.
    assign w_in_frame     = !RESET && (r_state == StSendFrame);
    assign RX_MFB_DST_RDY = w_in_frame && (r_drop || (|(r_sel_oh & TX_MFB_DST_RDY)));
    assign TX_MFB_SRC_RDY = (w_in_frame && RX_MFB_SRC_RDY) ? r_sel_oh : '0;
    assign w_frame_xfer   = RX_MFB_SRC_RDY && RX_MFB_DST_RDY;

    assign TX_MVB_SRC_RDY = r_mvb_vld;
    assign TX_MVB_HDR     = {OUTPUTS{r_hdr}};
    assign TX_MVB_PAYLOAD = {OUTPUTS{r_payload}};
    assign TX_MFB_DATA    = {OUTPUTS{RX_MFB_DATA}};
    assign TX_MFB_SOF     = {OUTPUTS{RX_MFB_SOF}};
    assign TX_MFB_EOF     = {OUTPUTS{RX_MFB_EOF}};
    assign TX_MFB_EOF_POS = {OUTPUTS{RX_MFB_EOF_POS}};
    assign DROP_CNT       = r_drop_cnt;

    always_ff @(posedge CLK) begin
        if (w_hdr_xfer) begin
            r_hdr <= RX_MVB_HDR;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= StWaitHdr;
            r_payload  <= 1'b0;
            r_drop     <= 1'b0;
            r_sel_oh   <= '0;
            r_mvb_vld  <= '0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                StWaitHdr: begin
                    if (w_hdr_xfer) begin
                        r_payload <= RX_MVB_PAYLOAD;
                        r_drop    <= w_in_drop;
                        r_sel_oh  <= w_in_drop ? '0 : w_in_oh;
                        r_mvb_vld <= w_in_drop ? '0 : w_in_oh;
                        if (w_in_drop) begin
                            r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
                        end
                        r_state <= StSendHdr;
                    end
                end
                StSendHdr: begin
                    if (w_hdr_done) begin
                        r_mvb_vld <= '0;
                        r_state   <= r_payload ? StSendFrame : StWaitHdr;
                    end
                end
                StSendFrame: begin
                    if (w_frame_xfer && RX_MFB_EOF) begin
                        r_state <= StWaitHdr;
                    end
                end
                default: r_state <= StWaitHdr;
            endcase
        end
    end

`ifdef MFB_SPLITTER_N_STATS_EN
    logic [OUTPUTS-1:0][CNT_WIDTH-1:0] r_frame_cnt;
    logic [OUTPUTS-1:0]                w_frame_done;

    // A frame is complete at its EOF transfer, or at the header transfer for header-only items.
    assign w_frame_done = (TX_MFB_SRC_RDY & TX_MFB_DST_RDY & {OUTPUTS{RX_MFB_EOF}})
                        | (TX_MVB_SRC_RDY & TX_MVB_DST_RDY & {OUTPUTS{!r_payload}});

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_frame_cnt <= '0;
        end else begin
            for (int i = 0; i < OUTPUTS; i++) begin
                if (w_frame_done[i]) begin
                    r_frame_cnt[i] <= r_frame_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign TX_FRAME_CNT = r_frame_cnt;
`endif

endmodule

// File: tb/tb_mfb_splitter_n.sv
// Self-checking bench for mfb_splitter_n: directed timing cases followed by randomized traffic
// checked against per-output expectation queues. Frame counters checked when stats are built in.
module tb_mfb_splitter_n;

    localparam int OUTPUTS  = 3;
    localparam int SW_WIDTH = 2;
    localparam int HW       = 16;
    localparam int BS       = 4;
    localparam int IW       = 8;
    localparam int CW       = 16;
    localparam int DW       = BS * IW;
    localparam int EPW      = 2;
    localparam int N_RAND   = 1000;
    localparam int LIMIT    = 500;

    logic                    CLK = 1'b0;
    logic                    RESET = 1'b1;
    logic [HW-1:0]           RX_MVB_HDR = '0;
    logic [SW_WIDTH-1:0]     RX_MVB_SWITCH = '0;
    logic                    RX_MVB_PAYLOAD = 1'b0;
    logic                    RX_MVB_SRC_RDY = 1'b0;
    logic                    RX_MVB_DST_RDY;
    logic [DW-1:0]           RX_MFB_DATA = '0;
    logic                    RX_MFB_SOF = 1'b0;
    logic                    RX_MFB_EOF = 1'b0;
    logic [EPW-1:0]          RX_MFB_EOF_POS = '0;
    logic                    RX_MFB_SRC_RDY = 1'b0;
    logic                    RX_MFB_DST_RDY;
    logic [OUTPUTS*HW-1:0]   TX_MVB_HDR;
    logic [OUTPUTS-1:0]      TX_MVB_PAYLOAD;
    logic [OUTPUTS-1:0]      TX_MVB_SRC_RDY;
    logic [OUTPUTS-1:0]      TX_MVB_DST_RDY = '1;
    logic [OUTPUTS*DW-1:0]   TX_MFB_DATA;
    logic [OUTPUTS-1:0]      TX_MFB_SOF;
    logic [OUTPUTS-1:0]      TX_MFB_EOF;
    logic [OUTPUTS*EPW-1:0]  TX_MFB_EOF_POS;
    logic [OUTPUTS-1:0]      TX_MFB_SRC_RDY;
    logic [OUTPUTS-1:0]      TX_MFB_DST_RDY = '1;
    logic [CW-1:0]           DROP_CNT;
`ifdef MFB_SPLITTER_N_STATS_EN
    logic [OUTPUTS*CW-1:0]   TX_FRAME_CNT;
`endif

    mfb_splitter_n #(
        .OUTPUTS        (OUTPUTS),
        .SW_WIDTH       (SW_WIDTH),
        .HDR_WIDTH      (HW),
        .MFB_BLOCK_SIZE (BS),
        .MFB_ITEM_WIDTH (IW),
        .CNT_WIDTH      (CW)
    ) u_dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .RX_MVB_HDR     (RX_MVB_HDR),
        .RX_MVB_SWITCH  (RX_MVB_SWITCH),
        .RX_MVB_PAYLOAD (RX_MVB_PAYLOAD),
        .RX_MVB_SRC_RDY (RX_MVB_SRC_RDY),
        .RX_MVB_DST_RDY (RX_MVB_DST_RDY),
        .RX_MFB_DATA    (RX_MFB_DATA),
        .RX_MFB_SOF     (RX_MFB_SOF),
        .RX_MFB_EOF     (RX_MFB_EOF),
        .RX_MFB_EOF_POS (RX_MFB_EOF_POS),
        .RX_MFB_SRC_RDY (RX_MFB_SRC_RDY),
        .RX_MFB_DST_RDY (RX_MFB_DST_RDY),
        .TX_MVB_HDR     (TX_MVB_HDR),
        .TX_MVB_PAYLOAD (TX_MVB_PAYLOAD),
        .TX_MVB_SRC_RDY (TX_MVB_SRC_RDY),
        .TX_MVB_DST_RDY (TX_MVB_DST_RDY),
        .TX_MFB_DATA    (TX_MFB_DATA),
        .TX_MFB_SOF     (TX_MFB_SOF),
        .TX_MFB_EOF     (TX_MFB_EOF),
        .TX_MFB_EOF_POS (TX_MFB_EOF_POS),
        .TX_MFB_SRC_RDY (TX_MFB_SRC_RDY),
        .TX_MFB_DST_RDY (TX_MFB_DST_RDY),
`ifdef MFB_SPLITTER_N_STATS_EN
        .TX_FRAME_CNT   (TX_FRAME_CNT),
`endif
        .DROP_CNT       (DROP_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic           sof;
        logic           eof;
        logic [EPW-1:0] pos;
    } word_t;

    typedef struct packed {
        logic [HW-1:0] hdr;
        logic          pl;
    } hdr_t;

    typedef struct packed {
        logic [HW-1:0]       hdr;
        logic [SW_WIDTH-1:0] sw;
        logic                pl;
    } drv_t;

    hdr_t  exp_hdr_q  [OUTPUTS][$];
    word_t exp_word_q [OUTPUTS][$];
    drv_t  drv_hdr_q  [$];
    word_t drv_word_q [$];
    word_t frm        [$];
    int    exp_frames [OUTPUTS];
    int    exp_drop;
    int    n_checks = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b0;
    bit    drv_abort = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic make_frame(input int items);
        word_t w;
        int    nw;
        frm.delete();
        nw = (items + BS - 1) / BS;
        for (int k = 0; k < nw; k++) begin
            w.data = DW'($urandom);
            w.sof  = (k == 0);
            w.eof  = (k == nw - 1);
            w.pos  = w.eof ? EPW'((items - 1) % BS) : '0;
            frm.push_back(w);
        end
    endtask

    task automatic drive_word(input word_t w);
        RX_MFB_SRC_RDY = 1'b1;
        RX_MFB_DATA    = w.data;
        RX_MFB_SOF     = w.sof;
        RX_MFB_EOF     = w.eof;
        RX_MFB_EOF_POS = w.pos;
    endtask

    task automatic check_stats(input int out);
`ifdef MFB_SPLITTER_N_STATS_EN
        check_eq("frame_cnt", TX_FRAME_CNT[out*CW +: CW], exp_frames[out]);
`endif
    endtask

    // Called at posedge+1; holds RESET for one cycle with source valids raised.
    task automatic do_reset();
        RESET = 1'b1;
        RX_MVB_SRC_RDY = 1'b1;
        RX_MFB_SRC_RDY = 1'b1;
        @(negedge CLK);
        check_eq("rst_mvb_dst", RX_MVB_DST_RDY, 0);
        check_eq("rst_mfb_dst", RX_MFB_DST_RDY, 0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        RX_MVB_SRC_RDY = 1'b0;
        exp_drop = 0;
        exp_frames = '{default: 0};
        @(negedge CLK);
        check_eq("rst_mvb_src", TX_MVB_SRC_RDY, 0);
        check_eq("rst_mfb_src", TX_MFB_SRC_RDY, 0);
        check_eq("rst_drop_cnt", DROP_CNT, exp_drop);
        check_eq("rst_mfb_not_consumed", RX_MFB_DST_RDY, 0);
        check_eq("rst_mvb_dst_idle", RX_MVB_DST_RDY, 1);
        for (int i = 0; i < OUTPUTS; i++) check_stats(i);
        @(posedge CLK); #1;
        RX_MFB_SRC_RDY = 1'b0;
    endtask

    // One header plus optional frame with all outputs ready, checked cycle by cycle.
    task automatic do_frame(input int sw, input bit pl, input int items,
                            input int stall_at, input int abort_at);
        logic [HW-1:0]      hdr;
        logic [OUTPUTS-1:0] oh;
        bit                 drop;
        int                 nw;
        int                 other;
        hdr   = HW'($urandom);
        drop  = (sw >= OUTPUTS);
        oh    = drop ? '0 : OUTPUTS'(1 << sw);
        other = (sw + 1) % OUTPUTS;
        make_frame(items);
        nw = pl ? frm.size() : 0;
        @(posedge CLK); #1;
        TX_MVB_DST_RDY = '1;
        TX_MFB_DST_RDY = '1;
        RX_MVB_SRC_RDY = 1'b1;
        RX_MVB_HDR     = hdr;
        RX_MVB_SWITCH  = SW_WIDTH'(sw);
        RX_MVB_PAYLOAD = pl;
        RX_MFB_SRC_RDY = 1'b0;
        @(negedge CLK);
        check_eq("hdr_accept_rdy", RX_MVB_DST_RDY, 1);
        @(posedge CLK); #1;
        RX_MVB_SRC_RDY = 1'b0;
        if (drop) exp_drop++;
        else exp_frames[sw]++;
        if (nw > 0) drive_word(frm[0]);
        @(negedge CLK);
        check_eq("mvb_src_rdy", TX_MVB_SRC_RDY, oh);
        check_eq("mfb_held_off", RX_MFB_DST_RDY, 0);
        check_eq("drop_cnt", DROP_CNT, exp_drop);
        if (!drop) begin
            check_eq("mvb_hdr", TX_MVB_HDR[sw*HW +: HW], hdr);
            check_eq("mvb_payload", TX_MVB_PAYLOAD[sw], pl);
        end
        for (int w = 0; w < nw; w++) begin
            @(posedge CLK); #1;
            drive_word(frm[w]);
            if (w == abort_at) begin
                do_reset();
                return;
            end
            if (w == stall_at) begin
                TX_MFB_DST_RDY[sw] = 1'b0;
                repeat (5) begin
                    @(negedge CLK);
                    check_eq("stall_rx_dst", RX_MFB_DST_RDY, 0);
                    check_eq("stall_tx_src", TX_MFB_SRC_RDY, oh);
                    @(posedge CLK); #1;
                end
                TX_MFB_DST_RDY = '1;
            end
            @(negedge CLK);
            check_eq("mfb_tx_src", TX_MFB_SRC_RDY, oh);
            check_eq("mfb_rx_dst", RX_MFB_DST_RDY, 1);
            if (!drop) begin
                check_eq("mfb_data", TX_MFB_DATA[sw*DW +: DW], frm[w].data);
                check_eq("mfb_data_bcast", TX_MFB_DATA[other*DW +: DW], frm[w].data);
                check_eq("mfb_sof", TX_MFB_SOF[sw], frm[w].sof);
                check_eq("mfb_eof", TX_MFB_EOF[sw], frm[w].eof);
                if (frm[w].eof) check_eq("mfb_eof_pos", TX_MFB_EOF_POS[sw*EPW +: EPW], frm[w].pos);
            end
        end
        @(posedge CLK); #1;
        RX_MFB_SRC_RDY = 1'b0;
        @(negedge CLK);
        check_eq("back_in_wait", RX_MVB_DST_RDY, 1);
        check_eq("idle_mvb_src", TX_MVB_SRC_RDY, 0);
        if (!drop) check_stats(sw);
    endtask

    task automatic mvb_drv();
        drv_t d;
        bit   got;
        int   t;
        while (drv_hdr_q.size() != 0 && !drv_abort) begin
            d = drv_hdr_q.pop_front();
            while ($urandom_range(0, 4) == 0) begin
                @(posedge CLK); #1;
            end
            RX_MVB_SRC_RDY = 1'b1;
            RX_MVB_HDR     = d.hdr;
            RX_MVB_SWITCH  = d.sw;
            RX_MVB_PAYLOAD = d.pl;
            got = 1'b0;
            t = 0;
            while (!got && t < LIMIT) begin
                @(negedge CLK);
                got = RX_MVB_DST_RDY;
                @(posedge CLK); #1;
                t++;
            end
            RX_MVB_SRC_RDY = 1'b0;
            check_eq("mvb_handshake", got, 1);
            if (!got) drv_abort = 1'b1;
        end
    endtask

    task automatic mfb_drv();
        word_t w;
        bit    got;
        int    t;
        while (drv_word_q.size() != 0 && !drv_abort) begin
            w = drv_word_q.pop_front();
            while ($urandom_range(0, 4) == 0) begin
                @(posedge CLK); #1;
            end
            drive_word(w);
            got = 1'b0;
            t = 0;
            while (!got && t < LIMIT) begin
                @(negedge CLK);
                got = RX_MFB_DST_RDY;
                @(posedge CLK); #1;
                t++;
            end
            RX_MFB_SRC_RDY = 1'b0;
            check_eq("mfb_handshake", got, 1);
            if (!got) drv_abort = 1'b1;
        end
    endtask

    // Scoreboard: every TX handshake must match the next expected item for that output.
    always @(negedge CLK) begin : mon
        hdr_t  h;
        word_t w;
        if (mon_en) begin
            for (int i = 0; i < OUTPUTS; i++) begin
                if (TX_MVB_SRC_RDY[i] && TX_MVB_DST_RDY[i]) begin
                    check_eq("hdr_expected", exp_hdr_q[i].size() != 0, 1);
                    if (exp_hdr_q[i].size() != 0) begin
                        h = exp_hdr_q[i].pop_front();
                        check_eq("rnd_hdr", TX_MVB_HDR[i*HW +: HW], h.hdr);
                        check_eq("rnd_payload", TX_MVB_PAYLOAD[i], h.pl);
                    end
                end
                if (TX_MFB_SRC_RDY[i] && TX_MFB_DST_RDY[i]) begin
                    check_eq("word_expected", exp_word_q[i].size() != 0, 1);
                    if (exp_word_q[i].size() != 0) begin
                        w = exp_word_q[i].pop_front();
                        check_eq("rnd_word", {TX_MFB_DATA[i*DW +: DW], TX_MFB_SOF[i],
                                 TX_MFB_EOF[i], TX_MFB_EOF_POS[i*EPW +: EPW]}, w);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drv_t d;
        int   sw;
        int   done;
        exp_drop = 0;
        exp_frames = '{default: 0};

        @(posedge CLK); #1;
        do_reset();

        do_frame(2, 1'b1, 10, -1, -1);
        do_frame(3, 1'b1, 6, -1, -1);
        check_eq("drop_cnt_one", DROP_CNT, 1);
        do_frame(1, 1'b0, 1, -1, -1);
        do_frame(0, 1'b1, 5, -1, -1);
        do_frame(1, 1'b1, 16, 2, -1);
        do_frame(0, 1'b1, 16, -1, 1);
        do_frame(2, 1'b0, 1, -1, -1);
        do_frame(1, 1'b1, 3, -1, -1);

        for (int n = 0; n < N_RAND; n++) begin
            sw   = $urandom_range(0, 3);
            d.hdr = HW'($urandom);
            d.sw  = SW_WIDTH'(sw);
            d.pl  = ($urandom_range(0, 3) != 0);
            drv_hdr_q.push_back(d);
            if (sw < OUTPUTS) begin
                exp_hdr_q[sw].push_back({d.hdr, d.pl});
                exp_frames[sw]++;
            end else begin
                exp_drop++;
            end
            if (d.pl) begin
                make_frame($urandom_range(1, 50));
                foreach (frm[k]) begin
                    drv_word_q.push_back(frm[k]);
                    if (sw < OUTPUTS) exp_word_q[sw].push_back(frm[k]);
                end
            end
        end

        @(posedge CLK); #1;
        mon_en = 1'b1;
        done = 0;
        fork
            begin mvb_drv(); done++; end
            begin mfb_drv(); done++; end
            begin
                while (done < 2) begin
                    for (int i = 0; i < OUTPUTS; i++) begin
                        TX_MVB_DST_RDY[i] = ($urandom_range(0, 4) != 0);
                        TX_MFB_DST_RDY[i] = ($urandom_range(0, 4) != 0);
                    end
                    @(posedge CLK); #1;
                end
            end
        join
        TX_MVB_DST_RDY = '1;
        TX_MFB_DST_RDY = '1;
        repeat (20) @(posedge CLK);
        #1;
        mon_en = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < OUTPUTS; i++) begin
            check_eq("hdr_q_drained", exp_hdr_q[i].size(), 0);
            check_eq("word_q_drained", exp_word_q[i].size(), 0);
            check_stats(i);
        end
        check_eq("rnd_drop_cnt", DROP_CNT, exp_drop);
        check_eq("rnd_end_idle", RX_MVB_DST_RDY, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
